// File: rtl/clk_div_multi_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Imported by the interface, the channel engine and the top level.
package clk_div_multi_pkg;

  localparam int CLK_DIV_MIN   = 2;
  localparam int CLK_DIV_DEPTH = 16;

  typedef struct packed {
    logic                     en;
    logic [CLK_DIV_DEPTH-1:0] div;
  } clk_div_cfg_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_t;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Configuration port of the divider: valid/ready request carrying
// target channel, new divisor and new enable.
interface clk_div_multi_if
  import clk_div_multi_pkg::*;
#(
  parameter int channels = 4,
  parameter int depth    = 16
);

  localparam int CHAN_W = chan_width(channels);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHAN_W-1:0] cfg_chan;
  logic [depth-1:0]  cfg_div;
  logic              cfg_en;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_div,
    output cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_div,
    input  cfg_en,
    output cfg_ready
  );

endinterface

// File: rtl/clk_div_multi_chan.sv
// One divider channel: period counter, active/pending configuration and
// registered divided waveform plus period-start tick.
//
// state   | meaning
// CH_IDLE | stopped; outputs low, count held at 0, pending config applied at once
// CH_RUN  | counting a period; pending config applied only at the period boundary
module clk_div_chan
  import clk_div_multi_pkg::*;
#(
  parameter int depth     = 16,
  parameter int reset_div = 2,
  parameter bit reset_en  = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [depth-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             pending,
  output logic             clock_slow,
  output logic             tick
);

  chan_state_t      state;
  logic [depth-1:0] count;
  logic [depth-1:0] div_act;
  logic [depth-1:0] div_pend;
  logic             en_act;
  logic             en_pend;

  logic [depth-1:0] neff;
  logic [depth-1:0] high_len;
  logic [depth-1:0] count_inc;
  logic [depth-1:0] div_next;
  logic             en_next;
  logic             boundary;

  // Divisors 0 and 1 clamp to 2; odd divisors put the extra cycle in the high phase.
  always_comb begin
    neff      = (div_act < depth'(CLK_DIV_MIN)) ? depth'(CLK_DIV_MIN) : div_act;
    high_len  = neff - (neff >> 1);
    count_inc = count + depth'(1);
    boundary  = (count == (neff - depth'(1)));
    div_next  = pending ? div_pend : div_act;
    en_next   = pending ? en_pend  : en_act;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CH_IDLE;
      count      <= '0;
      div_act    <= depth'(reset_div);
      en_act     <= reset_en;
      div_pend   <= '0;
      en_pend    <= 1'b0;
      pending    <= 1'b0;
      clock_slow <= 1'b0;
      tick       <= 1'b0;
    end else begin
      // The top only raises cfg_load while pending is clear, so the load never
      // collides with the pending-clear paths below.
      if (cfg_load) begin
        div_pend <= cfg_div;
        en_pend  <= cfg_en;
        pending  <= 1'b1;
      end

      case (state)
        CH_IDLE: begin
          count      <= '0;
          clock_slow <= 1'b0;
          tick       <= 1'b0;
          if (pending) begin
            div_act <= div_pend;
            en_act  <= en_pend;
            pending <= 1'b0;
          end else if (en_act) begin
            state      <= CH_RUN;
            clock_slow <= 1'b1;
            tick       <= 1'b1;
          end
        end

        CH_RUN: begin
          if (boundary) begin
            count   <= '0;
            div_act <= div_next;
            en_act  <= en_next;
            if (pending) begin
              pending <= 1'b0;
            end
            clock_slow <= en_next;
            tick       <= en_next;
            if (!en_next) begin
              state <= CH_IDLE;
            end
          end else begin
            count      <= count_inc;
            clock_slow <= (count_inc < high_len);
            tick       <= 1'b0;
          end
        end

        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Decodes the config port onto per-channel load strobes and generates the channels.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int channels  = 4,
  parameter int depth     = 16,
  parameter int reset_div = 2,
  parameter bit reset_en  = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  clk_div_multi_if.slave      cfg,
  output logic [channels-1:0] clock_slow,
  output logic [channels-1:0] tick
);

  localparam int CHAN_W = chan_width(channels);

  logic [channels-1:0] pending;
  logic [channels-1:0] load;
  logic                chan_ok;
  logic                ready_int;
  logic                accept;

  // Out-of-range channels always accept so the initiator never stalls on them.
  always_comb begin
    chan_ok   = (int'(cfg.cfg_chan) < channels);
    ready_int = chan_ok ? ~pending[cfg.cfg_chan] : 1'b1;
    accept    = cfg.cfg_valid & ready_int;
  end

  assign cfg.cfg_ready = ready_int;

  for (genvar i = 0; i < channels; i++) begin : g_chan
    assign load[i] = accept & (cfg.cfg_chan == CHAN_W'(i));

    clk_div_chan #(
      .depth     (depth),
      .reset_div (reset_div),
      .reset_en  (reset_en)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .cfg_load   (load[i]),
      .cfg_div    (cfg.cfg_div),
      .cfg_en     (cfg.cfg_en),
      .pending    (pending[i]),
      .clock_slow (clock_slow[i]),
      .tick       (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: divisor table on one channel plus
// hand-written sequences for disable, back-pressure, reset and dropped writes.
module tb_clk_div_multi;
  import clk_div_multi_pkg::*;

  logic       clock;
  logic       reset;
  logic [3:0] clock_slow;
  logic [3:0] tick;
  logic [2:0] clock_slow_b;
  logic [2:0] tick_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] cnt;
  logic [3:0]  mon_mask;
  bit          mon_b;

  clk_div_multi_if #(.channels(4), .depth(16)) ifc ();
  clk_div_multi_if #(.channels(3), .depth(16)) ifb ();

  clk_div_multi #(
    .channels (4), .depth (16), .reset_div (2), .reset_en (1'b1)
  ) dut (
    .clock (clock), .reset (reset), .cfg (ifc.slave),
    .clock_slow (clock_slow), .tick (tick)
  );

  // Non-power-of-two channel count so an out-of-range select is representable.
  clk_div_multi #(
    .channels (3), .depth (16), .reset_div (2), .reset_en (1'b1)
  ) dut_b (
    .clock (clock), .reset (reset), .cfg (ifb.slave),
    .clock_slow (clock_slow_b), .tick (tick_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycles since reset release; untouched div-2 channels follow its parity.
  always @(posedge clock) begin
    if (reset) cnt <= 16'd0;
    else       cnt <= cnt + 16'd1;
  end

  always @(negedge clock) begin
    if (!reset && mon_mask != 4'd0) begin
      checks++;
      if ((((clock_slow ^ {4{cnt[0]}}) | (tick ^ {4{cnt[0]}})) & mon_mask) != 4'd0) begin
        errors++;
        $display("FAIL untouched_channels: slow=%b tick=%b expected %b on mask %b",
                 clock_slow, tick, {4{cnt[0]}}, mon_mask);
      end
    end
    if (!reset && mon_b) begin
      checks++;
      if (clock_slow_b != {3{cnt[0]}} || tick_b != {3{cnt[0]}}) begin
        errors++;
        $display("FAIL dut_b_channels: slow=%b tick=%b expected %b",
                 clock_slow_b, tick_b, {3{cnt[0]}});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    clk_div_cfg_t cfg;
    int           hi;
    int           lo;
    string        name;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input int dv, input int hi, input int lo, input string nm);
    vec_t v;
    v.cfg.en  = 1'b1;
    v.cfg.div = dv[15:0];
    v.hi      = hi;
    v.lo      = lo;
    v.name    = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Holds a request until accepted; returns at the negedge after the accepting edge.
  task automatic cfg_write(input int ch, input int dv, input bit e);
    int w;
    w = 0;
    ifc.cfg_valid = 1'b1;
    ifc.cfg_chan  = ch[1:0];
    ifc.cfg_div   = dv[15:0];
    ifc.cfg_en    = e;
    #1;
    while (!ifc.cfg_ready && w < 2000) begin
      @(negedge clock);
      #1;
      w++;
    end
    check("cfg_accept", 64'(ifc.cfg_ready), 64'd1);
    @(negedge clock);
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic capture(input int c, input int n, output logic [63:0] cs_v, output logic [63:0] tk_v);
    cs_v = '0;
    tk_v = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clock);
      cs_v[i] = clock_slow[c];
      tk_v[i] = tick[c];
    end
  endtask

  task automatic find_tick(input int c, output bit found);
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clock);
      found = tick[c];
    end
  endtask

  // Waits for the period start carrying the new divisor, then checks one full period.
  task automatic run_vec(input int c, input int hi, input int lo, input string nm);
    int          per;
    bit          found;
    logic [63:0] acs, atk, ecs, etk;
    per = hi + lo;
    acs = '0; atk = '0; ecs = '0; etk = '0;
    find_tick(c, found);
    check({nm, "_apply"}, 64'(found), 64'd1);
    if (found) begin
      for (int k = 0; k <= per; k++) begin
        if (k > 0) @(negedge clock);
        acs[k] = clock_slow[c];
        atk[k] = tick[c];
        ecs[k] = (k < hi) || (k == per);
        etk[k] = (k == 0) || (k == per);
      end
      check({nm, "_slow"}, acs, ecs);
      check({nm, "_tick"}, atk, etk);
    end
  endtask

  task automatic check_default(input int n, input string nm);
    logic [3:0] exp;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      exp = (k % 2 == 0) ? 4'hF : 4'h0;
      check({nm, "_slow"}, 64'(clock_slow), 64'(exp));
      check({nm, "_tick"}, 64'(tick), 64'(exp));
    end
  endtask

  initial begin
    bit          found;
    int          hi;
    int          per;
    int          w;
    logic        cs0, tk0;
    logic [63:0] cs_v, tk_v;

    vecs[0] = mk(5, 3, 2, "div5");
    vecs[1] = mk(0, 1, 1, "div0");
    vecs[2] = mk(1, 1, 1, "div1");
    vecs[3] = mk(3, 2, 1, "div3");
    vecs[4] = mk(4, 2, 2, "div4");
    vecs[5] = mk(7, 4, 3, "div7");
    vecs[6] = mk(8, 4, 4, "div8");
    vecs[7] = mk(2, 1, 1, "div2");

    mon_mask = 4'd0;
    mon_b    = 1'b0;
    reset    = 1'b1;
    ifc.cfg_valid = 1'b0; ifc.cfg_chan = '0; ifc.cfg_div = '0; ifc.cfg_en = 1'b0;
    ifb.cfg_valid = 1'b0; ifb.cfg_chan = '0; ifb.cfg_div = '0; ifb.cfg_en = 1'b0;

    repeat (3) @(negedge clock);
    check("reset_slow", 64'(clock_slow), 64'd0);
    check("reset_tick", 64'(tick), 64'd0);
    check("reset_ready", 64'(ifc.cfg_ready), 64'd1);
    check("reset_b_slow", 64'(clock_slow_b), 64'd0);
    reset = 1'b0;
    mon_b = 1'b1;
    check_default(6, "start");

    mon_mask = 4'b1101;
    for (int i = 0; i < 8; i++) begin
      cfg_write(1, int'(vecs[i].cfg.div), vecs[i].cfg.en);
      run_vec(1, vecs[i].hi, vecs[i].lo, vecs[i].name);
    end

    // ch2: disable at count 0 of div 8, then re-enable from IDLE with div 3
    mon_mask = 4'b1001;
    cfg_write(2, 8, 1'b1);
    find_tick(2, found);
    check("ch2_div8_apply", 64'(found), 64'd1);
    cs0 = clock_slow[2];
    tk0 = tick[2];
    cfg_write(2, 8, 1'b0);
    capture(2, 12, cs_v, tk_v);
    check("ch2_disable_slow", {cs_v[50:0], cs0}, 64'h000F);
    check("ch2_disable_tick", {tk_v[50:0], tk0}, 64'h0001);
    cfg_write(2, 3, 1'b1);
    check("ch2_idle_pending_ready", 64'(ifc.cfg_ready), 64'd0);
    capture(2, 7, cs_v, tk_v);
    check("ch2_restart_slow", cs_v, 64'b1101100);
    check("ch2_restart_tick", tk_v, 64'b0100100);

    // ch0: back-to-back writes, second one stalls until the boundary
    mon_mask = 4'b1000;
    cfg_write(0, 1000, 1'b1);
    ifc.cfg_valid = 1'b1;
    ifc.cfg_chan  = 2'd0;
    ifc.cfg_div   = 16'd4;
    ifc.cfg_en    = 1'b1;
    #1;
    check("ch0_busy_ready", 64'(ifc.cfg_ready), 64'd0);
    w = 0;
    while (!ifc.cfg_ready && w < 10) begin
      @(negedge clock);
      #1;
      w++;
    end
    check("ch0_ready_at_boundary", 64'({ifc.cfg_ready, tick[0], clock_slow[0]}), 64'b111);
    @(negedge clock);
    ifc.cfg_valid = 1'b0;
    hi  = 1;
    per = -1;
    for (int k = 1; k < 1100; k++) begin
      if (k > 1) @(negedge clock);
      if (tick[0]) begin
        per = k;
        break;
      end
      hi += int'(clock_slow[0]);
    end
    check("ch0_div1000_period", 64'(per), 64'd1000);
    check("ch0_div1000_high", 64'(hi), 64'd500);
    capture(0, 5, cs_v, tk_v);
    check("ch0_div4_slow", cs_v, 64'b10011);
    check("ch0_div4_tick", tk_v, 64'b10001);

    // one-cycle reset with a write pending on ch3
    cfg_write(3, 9, 1'b1);
    check("ch3_pending_ready", 64'(ifc.cfg_ready), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_slow", 64'(clock_slow), 64'd0);
    check("midreset_tick", 64'(tick), 64'd0);
    check("midreset_ready", 64'(ifc.cfg_ready), 64'd1);
    reset = 1'b0;
    mon_mask = 4'b1111;
    check_default(12, "after_reset");

    // out-of-range select on the 3-channel instance is accepted and dropped
    ifb.cfg_valid = 1'b1;
    ifb.cfg_chan  = 2'd3;
    ifb.cfg_div   = 16'd5;
    ifb.cfg_en    = 1'b1;
    #1;
    check("oor_ready", 64'(ifb.cfg_ready), 64'd1);
    repeat (3) @(negedge clock);
    ifb.cfg_valid = 1'b0;
    repeat (12) @(negedge clock);

    mon_mask = 4'd0;
    mon_b    = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
